dds_phase_gen: RTL and testbench

- Phase-accumulator front end of the DDS function generator.
- Runs a 32-bit phase accumulator from a frequency tuning word (FTW) and produces the 11-bit ROM address that drives the coefficient lookup stage.
- Also produces a phase-wrap strobe and a sample-valid strobe delayed to line up with the lookup-table ROM output.
- FTW updates are double-buffered and applied at a phase wrap, so frequency changes are phase-continuous and glitch-free.

---
 rtl/dds_phase_gen.sv | 164 ++++++++++++++++
 tb/tb_dds_phase_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// dds_phase_gen -- phase-accumulator front end of the DDS function generator.
//
// Runs an ACC_W-bit phase accumulator from a frequency tuning word (FTW) and
// produces the registered ADDR_W-bit lookup ROM address (top accumulator bits
// plus a static phase offset). FTW updates are double-buffered and applied at a
// phase wrap so frequency changes are phase-continuous.
//
// Optional build macro: PHASE_DITHER_EN adds a 16-bit Galois LFSR whose low
// bits are added to the accumulator in the address path only (spur spreading).
//
// Ports:
//   Fg_CLK        system clock, rising edge
//   RESETn        synchronous active-low reset
//   run           1 = generate, 0 = stop and clear phase
//   ftw_in        new frequency tuning word
//   ftw_valid     ftw_in is valid
//   ftw_ready     block can accept ftw_in this cycle
//   phase_off     static phase offset added to the address, mod 2^ADDR_W
//   Address       registered ROM address
//   wrap          one-cycle pulse aligned with the first Address after a carry
//   sample_valid  ROM data for a RUN-cycle address is valid this cycle
//   state_dbg     current FSM state (0 = IDLE, 1 = RUN)
//
// FTW handshake: a word transfers on a rising edge where ftw_valid and
// ftw_ready are both 1. ftw_ready is ~pend (and 0 while RESETn is low);
// ftw_in must be held stable while ftw_valid=1 and ftw_ready=0.

module dds_phase_gen #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 11,
  parameter int ROM_LAT = 1
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              run,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic [ADDR_W-1:0] phase_off,
  output logic [ADDR_W-1:0] Address,
  output logic              wrap,
  output logic              sample_valid,
  output logic              state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]    ftw_shadow_q, ftw_shadow_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                carry_q, carry_d;
  logic                wrap_q, wrap_d;
  logic [ROM_LAT:0]    sv_q, sv_d;
  logic [ACC_W:0]      acc_sum;
  logic [ACC_W-1:0]    addr_acc;
  logic                xfer;

`ifdef PHASE_DITHER_EN
  localparam int DW = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;
  logic [15:0]         lfsr_q, lfsr_d;
`endif

  assign ftw_ready    = RESETn & ~pend_q;
  assign xfer         = ftw_valid & ftw_ready;
  assign Address      = address_q;
  assign wrap         = wrap_q;
  assign sample_valid = sv_q[ROM_LAT];
  assign state_dbg    = (state_q == RUN);
  assign acc_sum      = {1'b0, acc_q} + {1'b0, ftw_act_q};

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_act_d    = ftw_act_q;
    ftw_shadow_d = ftw_shadow_q;
    pend_d       = pend_q;
    carry_d      = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (xfer) ftw_act_d = ftw_in;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          acc_d   = '0;
          // Leaving RUN: a pending word becomes active immediately. A word
          // transferring on this same edge can only arrive with pend=0, so it
          // goes straight to the active register.
          if (pend_q) begin
            ftw_act_d = ftw_shadow_q;
            pend_d    = 1'b0;
          end else if (xfer) begin
            ftw_act_d = ftw_in;
          end
        end else begin
          acc_d   = acc_sum[ACC_W-1:0];
          carry_d = acc_sum[ACC_W];
          if (xfer) begin
            ftw_shadow_d = ftw_in;
            pend_d       = 1'b1;
          end else if (pend_q && (acc_sum[ACC_W] || (ftw_act_q == '0))) begin
            // A zero FTW never wraps, so apply the pending word right away.
            ftw_act_d = ftw_shadow_q;
            pend_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Carry is delayed one extra stage so wrap lines up with the Address
    // computed from the wrapped accumulator.
    wrap_d = carry_q;

    sv_d[0] = (state_q == RUN);
    for (int i = 1; i <= ROM_LAT; i++) sv_d[i] = sv_q[i-1];

`ifdef PHASE_DITHER_EN
    lfsr_d = lfsr_q;
    if (state_q == RUN)
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    addr_acc = acc_q + {{(ACC_W-DW){1'b0}}, lfsr_q[DW-1:0]};
`else
    addr_acc = acc_q;
`endif
    address_d = addr_acc[ACC_W-1 -: ADDR_W] + phase_off;
  end

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_act_q    <= '0;
      ftw_shadow_q <= '0;
      pend_q       <= 1'b0;
      address_q    <= '0;
      carry_q      <= 1'b0;
      wrap_q       <= 1'b0;
      sv_q         <= '0;
`ifdef PHASE_DITHER_EN
      lfsr_q       <= 16'hACE1;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_act_q    <= ftw_act_d;
      ftw_shadow_q <= ftw_shadow_d;
      pend_q       <= pend_d;
      address_q    <= address_d;
      carry_q      <= carry_d;
      wrap_q       <= wrap_d;
      sv_q         <= sv_d;
`ifdef PHASE_DITHER_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed testbench for dds_phase_gen (default parameters, ROM_LAT=1).
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] ftw_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [10:0] phase_off;
  logic [10:0] address;
  logic        wrap;
  logic        sample_valid;
  logic        state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dds_phase_gen dut (
    .Fg_CLK       (clk),
    .RESETn       (rst_n),
    .run          (run),
    .ftw_in       (ftw_in),
    .ftw_valid    (ftw_valid),
    .ftw_ready    (ftw_ready),
    .phase_off    (phase_off),
    .Address      (address),
    .wrap         (wrap),
    .sample_valid (sample_valid),
    .state_dbg    (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    run       = 1'b0;
    ftw_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic load_ftw(input logic [31:0] w);
    ftw_in    = w;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    run       = 1'b1;
    ftw_valid = 1'b0;
    ftw_in    = '0;
    phase_off = '0;
    repeat (3) tick();
    vectors++;
    if (ftw_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_in_reset got %b exp 0", ftw_ready);
    end
    rst_n = 1'b1;
    run   = 1'b0;
    tick();
    vectors++;
    if (address !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_addr got %h exp 000", address);
    end
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wrap got %b exp 0", wrap);
    end
    vectors++;
    if (sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sv got %b exp 0", sample_valid);
    end
    vectors++;
    if (ftw_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 1", ftw_ready);
    end
  endtask

  task automatic test_sweep();
    logic [10:0] ea;
    do_reset();
    phase_off = '0;
    load_ftw(32'h0020_0000);
    run = 1'b1;
    tick();
    vectors++;
    if (address !== 11'h000 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_entry addr %h sv %b exp 000 0", address, sample_valid);
    end
    for (int k = 1; k <= 2100; k++) begin
      tick();
      ea = 11'(k - 1);
      vectors++;
      if (address !== ea) begin
        miscompares++;
        $display("FAIL sweep_addr k=%0d got %h exp %h", k, address, ea);
      end
      vectors++;
      if (wrap !== (k == 2049)) begin
        miscompares++;
        $display("FAIL sweep_wrap k=%0d got %b exp %b", k, wrap, (k == 2049));
      end
      vectors++;
      if (sample_valid !== (k >= 2)) begin
        miscompares++;
        $display("FAIL sweep_sv k=%0d got %b exp %b", k, sample_valid, (k >= 2));
      end
    end
    run = 1'b0;
  endtask

  task automatic test_ftw_update();
    logic [10:0] ea;
    logic        er;
    logic        ew;
    do_reset();
    phase_off = '0;
    load_ftw(32'h0020_0000);
    run = 1'b1;
    tick();
    for (int k = 1; k <= 3080; k++) begin
      if (k == 11) begin
        vectors++;
        if (ftw_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL upd_ready_before got %b exp 1", ftw_ready);
        end
        ftw_in    = 32'h0040_0000;
        ftw_valid = 1'b1;
      end
      tick();
      ftw_valid = 1'b0;
      ea = (k <= 2049) ? 11'(k - 1) : 11'(2 * (k - 2049));
      er = !(k >= 11 && k <= 2047);
      ew = (k == 2049) || (k == 3073);
      vectors++;
      if (address !== ea) begin
        miscompares++;
        $display("FAIL upd_addr k=%0d got %h exp %h", k, address, ea);
      end
      vectors++;
      if (ftw_ready !== er) begin
        miscompares++;
        $display("FAIL upd_ready k=%0d got %b exp %b", k, ftw_ready, er);
      end
      vectors++;
      if (wrap !== ew) begin
        miscompares++;
        $display("FAIL upd_wrap k=%0d got %b exp %b", k, wrap, ew);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_phase_off();
    logic [10:0] ea;
    do_reset();
    phase_off = 11'h400;
    load_ftw(32'h0020_0000);
    vectors++;
    if (address !== 11'h400) begin
      miscompares++;
      $display("FAIL poff_idle got %h exp 400", address);
    end
    run = 1'b1;
    for (int k = 0; k <= 2060; k++) begin
      tick();
      ea = (k == 0) ? 11'h400 : 11'(k - 1 + 'h400);
      vectors++;
      if (address !== ea) begin
        miscompares++;
        $display("FAIL poff_addr k=%0d got %h exp %h", k, address, ea);
      end
      vectors++;
      if (wrap !== (k == 2049)) begin
        miscompares++;
        $display("FAIL poff_wrap k=%0d got %b exp %b", k, wrap, (k == 2049));
      end
    end
    run = 1'b0;
  endtask

  task automatic test_run_stop();
    logic [10:0] exp_a [7];
    logic        exp_s [3];
    exp_a = '{11'd117, 11'd16, 11'd16, 11'd16, 11'd16, 11'd18, 11'd20};
    exp_s = '{1'b1, 1'b1, 1'b0};
    do_reset();
    phase_off = 11'h010;
    load_ftw(32'h0020_0000);
    run = 1'b1;
    repeat (101) tick();
    ftw_in    = 32'h0040_0000;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    vectors++;
    if (address !== 11'd116 || ftw_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_pending addr %0d ready %b exp 116 0", address, ftw_ready);
    end
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) run = 1'b1;
      tick();
      vectors++;
      if (address !== exp_a[i]) begin
        miscompares++;
        $display("FAIL stop_addr i=%0d got %0d exp %0d", i, address, exp_a[i]);
      end
      if (i < 3) begin
        vectors++;
        if (sample_valid !== exp_s[i] || wrap !== 1'b0 || ftw_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stop_flags i=%0d sv %b wrap %b ready %b exp %b 0 1",
                   i, sample_valid, wrap, ftw_ready, exp_s[i]);
        end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_ftw_zero();
    logic [10:0] exp_a [4];
    exp_a = '{11'h123, 11'h123, 11'h124, 11'h125};
    do_reset();
    phase_off = 11'h123;
    run = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (address !== 11'h123) begin
        miscompares++;
        $display("FAIL zero_hold i=%0d got %h exp 123", i, address);
      end
    end
    ftw_in    = 32'h0020_0000;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    vectors++;
    if (ftw_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_ready_pend got %b exp 0", ftw_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (address !== exp_a[i] || ftw_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_apply i=%0d addr %h ready %b exp %h 1",
                 i, address, ftw_ready, exp_a[i]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset_discard();
    do_reset();
    phase_off = '0;
    load_ftw(32'h0020_0000);
    run = 1'b1;
    repeat (4) tick();
    ftw_in    = 32'h0040_0000;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (address !== 11'h000 || ftw_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL discard i=%0d addr %h ready %b exp 000 1", i, address, ftw_ready);
      end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_ftw_update();
    test_phase_off();
    test_run_stop();
    test_ftw_zero();
    test_reset_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
